// File: rtl/sweep_ctrl.sv
// Triangle-sweep sequencer driving an 8-bit up/down load counter.
// The sweep runs LOW -> HIGH -> LOW, either once or continuously, with a programmable step period.
module sweep_ctrl #(
    parameter int PSC_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic       wr_en,
    input  logic [1:0] wr_sel,
    input  logic [7:0] wr_data,
    output logic       cnt_en,
    output logic       cnt_load,
    output logic       cnt_up,
    output logic [7:0] cnt_d,
    output logic [7:0] pos,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        UP   = 2'd2,
        DOWN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         low_q, high_q;
    logic [PSC_W-1:0]   psc_q;
    logic [PSC_W-1:0]   psc_cnt_q, psc_cnt_d;
    logic [7:0]         pos_q, pos_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               tick;
    logic [7:0]         pos_inc, pos_dec;

    assign tick    = ((state_q == UP) || (state_q == DOWN)) && (psc_cnt_q == psc_q);
    assign pos_inc = pos_q + 8'd1;
    assign pos_dec = pos_q - 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            psc_cnt_q <= '0;
            pos_q     <= 8'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            psc_cnt_q <= psc_cnt_d;
            pos_q     <= pos_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Configuration is frozen while a sweep is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low_q  <= 8'd0;
            high_q <= 8'd255;
            psc_q  <= '0;
        end else if (wr_en && (state_q == IDLE)) begin
            case (wr_sel)
                2'd0:    low_q  <= wr_data;
                2'd1:    high_q <= wr_data;
                2'd2:    psc_q  <= PSC_W'(wr_data);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        psc_cnt_d = psc_cnt_q;
        pos_d     = pos_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    if (low_q > high_q) err_d   = 1'b1;
                    else                state_d = LOAD;
                end
            end
            LOAD: begin
                pos_d     = low_q;
                psc_cnt_d = '0;
                if (low_q == high_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = UP;
                end
            end
            UP: begin
                psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
                if (tick) begin
                    pos_d = pos_inc;
                    if (pos_inc == high_q) state_d = DOWN;
                end
            end
            DOWN: begin
                psc_cnt_d = tick ? '0 : psc_cnt_q + 1'b1;
                if (tick) begin
                    pos_d = pos_dec;
                    if (pos_dec == low_q) begin
                        if (cont) begin
                            state_d = UP;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A step already enabled this cycle still lands in pos, keeping it equal to the counter.
        if (stop) begin
            state_d = IDLE;
            done_d  = 1'b0;
        end
    end

    assign cnt_en    = tick;
    assign cnt_load  = (state_q == LOAD);
    assign cnt_up    = (state_q != DOWN);
    assign cnt_d     = low_q;
    assign pos       = pos_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: doc/sweep_ctrl.md
# sweep_ctrl

Programmable triangle-sweep sequencer that sits directly upstream of the 8-bit up/down load counter and drives its en/load/up/d controls. Software programs LOW, HIGH and PRESCALE registers; on start the block loads LOW into the counter, then steps it up to HIGH and back down to LOW, once or continuously, at one step per PRESCALE+1 clocks. An internal shadow position mirrors the counter value, assuming the counter is driven only by this block.

## Interface
- PSC_W, 8, width of the PRESCALE register and the prescale counter.

- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a sweep; sampled only in IDLE.
- stop  in  1  abort the sweep; priority over start.
- cont  in  1  1 = ping-pong forever; 0 = single sweep LOW→HIGH→LOW. Sampled at each turn at LOW.
- wr_en  in  1  config write strobe.
- wr_sel  in  2  0 = LOW, 1 = HIGH, 2 = PRESCALE, 3 = ignored.
- wr_data  in  8  write data. PRESCALE takes bits [PSC_W-1:0], zero-extended if PSC_W > 8.
- cnt_en  out  1  counter count enable.
- cnt_load  out  1  counter synchronous load.
- cnt_up  out  1  counter direction.
- cnt_d  out  8  counter load value; always equals LOW.
- pos  out  8  shadow counter value.
- busy  out  1  high in LOAD, UP and DOWN.
- done  out  1  one-cycle pulse when a single sweep completes.
- err  out  1  one-cycle pulse when start is rejected.

## Operation
- States: IDLE, LOAD, UP, DOWN.
- All outputs are decoded from registered state only. There is no combinational path from any input to any output.
- Config writes are accepted only in IDLE. Writes while busy=1 are dropped.
- IDLE:
  - cnt_en=0, cnt_load=0.
  - On start with stop=0:
    - If LOW>HIGH: stay in IDLE and pulse err next cycle.
    - Otherwise go to LOAD.
- LOAD (exactly 1 cycle):
  - cnt_load=1, cnt_d=LOW, cnt_en=0.
  - pos←LOW.
  - If LOW==HIGH, go to IDLE and pulse done. Otherwise go to UP with psc_cnt←0.
- Tick: the cycle in which psc_cnt==PRESCALE in UP or DOWN. psc_cnt then resets to 0; in all other cycles it increments.
- Direction changes do not reset psc_cnt, so step spacing is uniform across turns.
- UP:
  - cnt_up=1; cnt_en=tick.
  - On tick, pos←pos+1. If pos+1==HIGH, go to DOWN.
- DOWN:
  - cnt_up=0; cnt_en=tick.
  - On tick, pos←pos−1. If pos−1==LOW: go to UP if cont=1; otherwise go to IDLE and pulse done.
- cnt_up=1 in IDLE and LOAD.
- Arithmetic is 8-bit. The LOW≤HIGH check guarantees pos never wraps, including LOW=0 and HIGH=255.
- stop in any state: next state is IDLE. cnt_en and cnt_load are 0 from the next cycle, pos holds, and done does not pulse.
- start while busy is ignored.
- Reset values:
  - State IDLE; LOW=0, HIGH=255, PRESCALE=0; psc_cnt=0; pos=0.
  - cnt_en=0, cnt_load=0, cnt_up=1, cnt_d=0, busy=0, done=0, err=0.
- Reset asserted mid-sweep returns everything to reset values immediately, with no done pulse.

## Timing
- start high in cycle 0 (IDLE) → LOAD in cycle 1 (cnt_load=1, busy=1) → first UP cycle is cycle 2.
- pos updates on the same edge at which the counter consumes cnt_en or cnt_load, so pos equals the counter value every cycle.
- Step period is PRESCALE+1 cycles. First cnt_en occurs in cycle 2+PRESCALE.
- Single sweep:
  - 2·(HIGH−LOW) cnt_en pulses.
  - done is high in the first IDLE cycle after the final tick, with busy=0 in that same cycle.
- err and done are exactly 1 cycle wide.
- A new start is accepted in the cycle done is high.

## Test plan
- Reset mid-sweep (LOW=10, HIGH=20, cont=1, drop rst_n during DOWN): all outputs return to reset values asynchronously; a write of LOW=2 after release takes effect.
- Single sweep (LOW=3, HIGH=5, PRESCALE=0, cont=0, start): cnt_load in cycle 1 with cnt_d=3. cnt_en in cycles 2–5. pos sequence is 3,4,5,4,3 and cnt_up goes 1,1,0,0. done in cycle 6.
- Prescale (LOW=0, HIGH=2, PRESCALE=3): cnt_en pulses exactly every 4 cycles, first in cycle 5. Total 4 pulses, then done.
- Continuous plus stop (LOW=250, HIGH=255, cont=1): pos ping-pongs 250↔255 with no wrap. After stop, cnt_en=0 from the next cycle, pos holds, busy=0, and no done.
- Boundaries:
  - LOW=7, HIGH=7, start: single LOAD cycle, then done, with zero cnt_en pulses.
  - LOW=9, HIGH=8, start: err pulse and busy stays 0.
  - A wr_en to HIGH while busy leaves HIGH unchanged.
- Simultaneous start+stop in IDLE: stays in IDLE with no LOAD. start pulsed during UP is ignored.
